// File: rtl/ins_loader.sv
// Boot-time instruction memory loader: takes a length-prefixed, XOR-checksummed byte
// stream, assembles big-endian words, writes them from address 0 and holds the CPU until verified.
module ins_loader #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       len_hi;
  logic [IDX_W:0]   len_words;
  logic [IDX_W-1:0] word_index;
  logic [1:0]       byte_cnt;
  logic [7:0]       csum;
  logic [23:0]      word_reg;

  logic        xfer;
  logic [15:0] len_full;
  logic        last_word;
  logic        start_ok;

  assign xfer      = byte_valid && byte_ready;
  assign len_full  = {len_hi, byte_data};
  assign last_word = (({1'b0, word_index} + (IDX_W+1)'(1)) == len_words);
  assign start_ok  = load_start && (state == S_IDLE || state == S_DONE || state == S_ERR);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    cpu_hold   = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start) state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (xfer) state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (xfer) begin
          if (len_full > 16'(MEM_WORDS)) state_nxt = S_ERR;
          else if (len_full == 16'd0)    state_nxt = S_CHECK;
          else                           state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (xfer && byte_cnt == 2'd3 && last_word) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        cpu_hold   = 1'b1;
        if (xfer) state_nxt = (byte_data == csum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done = 1'b1;
        if (load_start) state_nxt = S_LEN_HI;
      end
      S_ERR: begin
        cpu_hold = 1'b1;
        error    = 1'b1;
        if (load_start) state_nxt = S_LEN_HI;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Word assembly and the write port; the index stops at N-1 so the address never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_hi     <= '0;
      len_words  <= '0;
      word_index <= '0;
      byte_cnt   <= '0;
      csum       <= '0;
      word_reg   <= '0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      mem_wr <= 1'b0;
      if (start_ok) begin
        word_index <= '0;
        byte_cnt   <= '0;
        csum       <= '0;
      end
      case (state)
        S_LEN_HI: if (xfer) len_hi <= byte_data;
        S_LEN_LO: if (xfer) len_words <= len_full[IDX_W:0];
        S_DATA: begin
          if (xfer) begin
            word_reg <= {word_reg[15:0], byte_data};
            csum     <= csum ^ byte_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_wr    <= 1'b1;
              mem_addr  <= 32'({word_index, 2'b00});
              mem_wdata <= {word_reg, byte_data};
              if (!last_word) word_index <= word_index + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
